// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_uart_tx : drains an upstream FIFO one byte per 8N1 UART frame
// Revision     : 1.0
// ----------------------------------------------------------------------------
module fifo_uart_tx #(
   parameter int BAUD_DIV = 10416
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_pop,
   output logic       tx,
   output logic       tx_busy
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] baud_cnt, baud_nx;
   logic [2:0]    bit_cnt, bit_nx;
   logic [7:0]    shreg, shreg_nx;
   logic          tx_nx;
   logic          boundary;

   always_comb begin
      fifo_pop = (state == IDLE) && !fifo_empty && !rst;
      boundary = (baud_cnt == BAUD_LAST);
      state_nx = state;
      baud_nx  = boundary ? '0 : baud_cnt + CW'(1);
      bit_nx   = bit_cnt;
      shreg_nx = shreg;
      tx_nx    = tx;

      case (state)
         IDLE: begin
            baud_nx = '0;
            tx_nx   = 1'b1;
            if (fifo_pop) begin
               state_nx = START;
               shreg_nx = fifo_data;
               bit_nx   = 3'd0;
               tx_nx    = 1'b0;
            end
         end
         START: begin
            if (boundary) begin
               state_nx = DATA;
               tx_nx    = shreg[0];
            end
         end
         DATA: begin
            if (boundary) begin
               shreg_nx = {1'b0, shreg[7:1]};
               bit_nx   = bit_cnt + 3'd1;
               // the next bit is shreg[1], the one that lands in the LSB after this shift
               if (bit_cnt == 3'd7) begin
                  state_nx = STOP;
                  tx_nx    = 1'b1;
               end else begin
                  tx_nx = shreg[1];
               end
            end
         end
         STOP: begin
            if (boundary) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= 3'd0;
         shreg    <= 8'd0;
      end else begin
         state    <= state_nx;
         tx       <= tx_nx;
         tx_busy  <= (state_nx != IDLE);
         baud_cnt <= baud_nx;
         bit_cnt  <= bit_nx;
         shreg    <= shreg_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fifo_uart_tx : directed bench for fifo_uart_tx with a 4-deep FIFO model
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_fifo_uart_tx;

   localparam int BD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data = 8'd0;
   logic       fifo_pop;
   logic       tx;
   logic       tx_busy;

   fifo_uart_tx #(.BAUD_DIV(BD)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_pop   (fifo_pop),
      .tx         (tx),
      .tx_busy    (tx_busy)
   );

   always #5 clk = ~clk;

   // frame is the expected line level per bit period in time order: start, b0..b7, stop
   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
   } vec_t;

   vec_t       vecs[8];
   logic [7:0] mem[4];
   int         rd = 0, wr = 0, cnt = 0;
   int         total = 0, bad = 0, cyc_n = 0;
   logic       pop_q = 1'b0, s_tx = 1'b1, s_busy = 1'b0;
   bit         scramble = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   task automatic push(input logic [7:0] d);
      mem[wr] = d;
      wr      = (wr + 1) % 4;
      cnt++;
   endtask

   task automatic resample();
      #1;
      pop_q  = fifo_pop;
      s_tx   = tx;
      s_busy = tx_busy;
   endtask

   // one clock: retire a pop seen before the edge, drive new inputs, sample outputs
   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
      if (pop_q) begin
         chk("pop_nonempty", 32'(cnt > 0), 32'd1);
         if (cnt > 0) begin
            rd = (rd + 1) % 4;
            cnt--;
         end
      end
      if (scramble) begin
         fifo_empty = 1'($urandom_range(0, 1));
         fifo_data  = 8'($urandom);
      end else begin
         fifo_empty = (cnt == 0);
         fifo_data  = (cnt == 0) ? 8'($urandom) : mem[rd];
      end
      resample();
   endtask

   task automatic wait_pop();
      int n = 0;
      while (!pop_q && n < 60) begin
         cyc();
         n++;
      end
      chk("pop_seen", 32'(pop_q), 32'd1);
   endtask

   task automatic run_frame(input logic [9:0] fr, input bit scr, output int pop_at);
      int pops = 0;
      wait_pop();
      pop_at = cyc_n;
      for (int k = 0; k < 10 * BD; k++) begin
         scramble = scr;
         cyc();
         chk($sformatf("frame_tx[%0d]", k), 32'(s_tx), 32'(fr[9 - k / BD]));
         chk($sformatf("frame_busy[%0d]", k), 32'(s_busy), 32'd1);
         pops += int'(pop_q);
      end
      scramble = 1'b0;
      chk("pops_mid_frame", pops, 0);
      cyc();
      chk("idle_busy", 32'(s_busy), 32'd0);
      chk("idle_tx", 32'(s_tx), 32'd1);
   endtask

   initial begin
      int p, p1, p2;
      logic [9:0] fr_ff;

      vecs[0] = '{8'hA5, 10'b0101001011};
      vecs[1] = '{8'h00, 10'b0000000001};
      vecs[2] = '{8'hFF, 10'b0111111111};
      vecs[3] = '{8'h01, 10'b0100000001};
      vecs[4] = '{8'h80, 10'b0000000011};
      vecs[5] = '{8'h0F, 10'b0111100001};
      vecs[6] = '{8'h55, 10'b0101010101};
      vecs[7] = '{8'h3C, 10'b0001111001};
      fr_ff   = 10'b0111111111;

      // reset state
      rst = 1'b1;
      repeat (3) cyc();
      chk("rst_tx", 32'(s_tx), 32'd1);
      chk("rst_busy", 32'(s_busy), 32'd0);
      chk("rst_pop", 32'(pop_q), 32'd0);
      rst = 1'b0;
      resample();

      // empty FIFO: line stays idle
      for (int i = 0; i < 200; i++) begin
         cyc();
         chk("empty_pop", 32'(pop_q), 32'd0);
         chk("empty_tx", 32'(s_tx), 32'd1);
         chk("empty_busy", 32'(s_busy), 32'd0);
      end

      // single-byte frames from the table
      for (int i = 0; i < 8; i++) begin
         push(vecs[i].data);
         run_frame(vecs[i].frame, 1'b0, p);
         chk($sformatf("drained[%0d]", i), cnt, 0);
      end

      // back-to-back frames
      push(8'h55);
      push(8'h0F);
      run_frame(10'b0101010101, 1'b0, p1);
      run_frame(10'b0111100001, 1'b0, p2);
      chk("b2b_spacing", p2 - p1, 41);

      // FIFO inputs wiggle throughout the frame
      push(8'h3C);
      run_frame(10'b0001111001, 1'b1, p);
      chk("scramble_drained", cnt, 0);

      // fill the 4-deep FIFO, then drain in order
      push(8'h11);
      push(8'h22);
      push(8'h33);
      push(8'h44);
      run_frame(10'b0100010001, 1'b0, p);
      run_frame(10'b0010001001, 1'b0, p);
      run_frame(10'b0110011001, 1'b0, p);
      run_frame(10'b0001000101, 1'b0, p);
      chk("full_drained", cnt, 0);
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("drained_pop", 32'(pop_q), 32'd0);
         chk("drained_busy", 32'(s_busy), 32'd0);
      end

      // reset during data bit 3 of 0xFF, with 0x81 waiting in the FIFO
      push(8'hFF);
      push(8'h81);
      wait_pop();
      for (int k = 0; k < 19; k++) begin
         cyc();
         chk($sformatf("abort_tx[%0d]", k), 32'(s_tx), 32'(fr_ff[9 - k / BD]));
      end
      rst = 1'b1;
      resample();
      chk("abort_pop_pre", 32'(pop_q), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("abort_tx_idle", 32'(s_tx), 32'd1);
         chk("abort_busy", 32'(s_busy), 32'd0);
         chk("abort_no_pop", 32'(pop_q), 32'd0);
      end
      chk("abort_fifo_kept", cnt, 1);
      rst = 1'b0;
      resample();
      chk("release_pop", 32'(pop_q), 32'd1);
      run_frame(10'b0100000011, 1'b0, p);
      chk("abort_drained", cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 10416 (100 MHz / 9600 baud): clock cycles per UART bit; legal range >= 2.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port fifo_empty  input  1  empty flag from the upstream FIFO.
REQ-005 SHALL have port fifo_data  input  8  upstream FIFO head word, combinational, valid whenever fifo_empty=0.
REQ-006 SHALL have port fifo_pop  output  1  pop strobe to the upstream FIFO.
REQ-007 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-008 SHALL have port tx_busy  output  1  high while a frame is in progress.

Function
REQ-009 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-010 SHALL drive fifo_pop combinationally as (state==IDLE && fifo_empty==0); it is never high in any other state.
REQ-011 SHALL capture fifo_data into an 8-bit shift register on the same edge where fifo_pop=1, transition IDLE->START, and clear the baud counter and bit counter.
REQ-012 SHALL therefore issue exactly one pop per frame; the FIFO's empty update one cycle later is ignored because state is no longer IDLE.
REQ-013 SHALL register tx; tx=0 from the cycle after the pop edge for exactly BAUD_DIV cycles (START).
REQ-014 SHALL use a baud counter of width clog2(BAUD_DIV) counting 0..BAUD_DIV-1; the bit boundary is the cycle where the count equals BAUD_DIV-1, after which it wraps to 0.
REQ-015 SHALL, at the START boundary, enter DATA and drive the shift register LSB on tx.
REQ-016 SHALL, in DATA, hold each bit for BAUD_DIV cycles, LSB first, shifting right at each boundary; a 3-bit bit counter advances per boundary, and after bit 7 completes, enter STOP.
REQ-017 SHALL, in STOP, drive tx=1 for BAUD_DIV cycles, then return to IDLE.
REQ-018 SHALL spend at least one cycle in IDLE between frames; back-to-back frame period = 10*BAUD_DIV+1 cycles.
REQ-019 SHALL drive tx_busy = (state != IDLE), registered with the state.
REQ-020 SHALL hold tx=1 and fifo_pop=0 in IDLE while fifo_empty=1, indefinitely.
REQ-021 SHALL not sample fifo_data or fifo_empty outside IDLE; changes mid-frame have no effect on the frame.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, set state=IDLE, tx=1, tx_busy=0, baud counter=0, bit counter=0, shift register=0.
REQ-023 SHALL hold fifo_pop=0 during any cycle where rst=1, regardless of fifo_empty.
REQ-024 SHALL, when reset is asserted mid-frame, abort the frame with tx=1 from the next cycle; the already-popped byte is discarded, never retransmitted.
REQ-025 SHALL begin a new frame no earlier than the first cycle after rst deasserts, if fifo_empty=0.

Verification
REQ-026 Single byte, BAUD_DIV=4: fifo_data=0xA5, fifo_empty=0 for one cycle -> one fifo_pop pulse; tx = 0 (4 cycles), then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 (4 cycles); tx_busy high for 40 cycles.
REQ-027 Back-to-back, BAUD_DIV=4: FIFO holds 0x55,0x0F -> exactly two pops spaced 41 cycles apart; second start bit begins 41 cycles after the first.
REQ-028 Empty hold: fifo_empty=1 for 200 cycles after reset -> fifo_pop=0, tx=1, tx_busy=0 throughout.
REQ-029 Mid-frame reset: rst pulsed during DATA bit 3 of 0xFF -> the next cycle tx=1 and tx_busy=0; no re-pop while rst=1; a new frame starts one cycle after release if fifo_empty=0.
REQ-030 Data change mid-frame: fifo_data toggled each cycle during a 0x3C frame -> serialized bits still match 0x3C; a single pop.
REQ-031 Integration with the 4-deep FIFO: push 4 bytes (full=1), then run -> 4 frames in push order, FIFO empty after the 4th pop, no pop while empty.
